// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channel between the memory-access stage and the data memory.
interface dmem_responder_if #(parameter int XLEN = 32);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [1:0]      req_size_i;
  logic            req_unsigned_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_we_o;
  logic            rsp_misalign_o;
  logic            rsp_bus_err_o;
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_misalign_o, rsp_bus_err_o
  );
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_we_o, rsp_misalign_o, rsp_bus_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressable data SRAM with lane-masked stores, extended loads and fault flags.
module dmem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 256,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int              LANES = XLEN / 8;
  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(4 * DEPTH_WORDS);
  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic             rsp_we_q, rsp_we_d;
  logic             rsp_mis_q, rsp_mis_d;
  logic             rsp_err_q, rsp_err_d;
  logic             accept, misalign, bus_err, fault, wr_en;
  logic [1:0]       lane, size;
  logic [XLEN-1:0]  off, rd_word, ld_data, wr_data;
  logic [15:0]      rd_low;
  logic [IDX_W-1:0] idx;
  logic [LANES-1:0] wr_be;
  assign bus.req_ready_o    = rst_n & (~rsp_valid_q | bus.rsp_ready_i);
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_rdata_o    = rsp_rdata_q;
  assign bus.rsp_we_o       = rsp_we_q;
  assign bus.rsp_misalign_o = rsp_mis_q;
  assign bus.rsp_bus_err_o  = rsp_err_q;
  always_comb begin
    accept   = bus.req_valid_i & bus.req_ready_o;
    size     = bus.req_size_i;
    lane     = bus.req_addr_i[1:0];
    off      = bus.req_addr_i - BASE_ADDR;
    misalign = (size == 2'b01 & lane[0]) | (size == 2'b10 & |lane);
    // unsigned compare: addresses below BASE_ADDR wrap to huge offsets and fault
    bus_err  = ~misalign & (size == 2'b11 | off >= LIMIT);
    fault    = misalign | bus_err;
    idx      = off[IDX_W+1:2];
    rd_word  = mem_q[idx];
    // aligned halves have lane[0]=0, so a lane*8 shift serves both byte and half
    rd_low   = 16'(rd_word >> {lane, 3'b000});
    ld_data  = size == 2'b00 ? (bus.req_unsigned_i ? {{(XLEN-8){1'b0}}, rd_low[7:0]}
                                                   : {{(XLEN-8){rd_low[7]}}, rd_low[7:0]})
             : size == 2'b01 ? (bus.req_unsigned_i ? {{(XLEN-16){1'b0}}, rd_low}
                                                   : {{(XLEN-16){rd_low[15]}}, rd_low})
             : rd_word;
    wr_be    = size == 2'b00 ? LANES'(1) << lane : size == 2'b01 ? LANES'(3) << lane : '1;
    wr_data  = size == 2'b00 ? {LANES{bus.req_wdata_i[7:0]}}
             : size == 2'b01 ? {(LANES/2){bus.req_wdata_i[15:0]}} : bus.req_wdata_i;
    wr_en    = accept & bus.req_we_i & ~fault;
  end
  always_comb begin
    rsp_valid_d = accept | (rsp_valid_q & ~bus.rsp_ready_i);
    rsp_rdata_d = accept ? ((bus.req_we_i | fault) ? '0 : ld_data) : rsp_rdata_q;
    rsp_we_d    = accept ? bus.req_we_i : rsp_we_q;
    rsp_mis_d   = accept ? misalign : rsp_mis_q;
    rsp_err_d   = accept ? bus_err : rsp_err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_we_q    <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_we_q    <= rsp_we_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < LANES; b++)
        if (wr_be[b]) mem_q[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed traffic checked against a byte-array reference model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0]  ref_mem [1024];
  logic        exp_valid = 1'b0, exp_we = 1'b0, exp_mis = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;
  always #5 clk = ~clk;
  dmem_responder_if #(.XLEN(32)) bus ();
  dmem_responder #(.XLEN(32), .DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns);
    logic [31:0] off, v;
    logic [9:0]  a;
    int n;
    off = addr;
    n = 1 << size;
    exp_we = we;
    exp_mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    exp_err = !exp_mis && (size == 2'd3 || off >= 32'd1024);
    exp_rdata = '0;
    if (!exp_mis && !exp_err) begin
      v = '0;
      for (int i = 0; i < n; i++) begin
        a = off[9:0] + 10'(i);
        if (we) ref_mem[a] = wdata[8*i +: 8];
        else v[8*i +: 8] = ref_mem[a];
      end
      if (!we && n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      if (!we) exp_rdata = v;
    end
  endtask
  task automatic cyc(input logic v, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input logic rr);
    logic exp_ready, in_reset;
    bus.req_valid_i = v;
    bus.req_we_i = we;
    bus.req_addr_i = addr;
    bus.req_wdata_i = wdata;
    bus.req_size_i = size;
    bus.req_unsigned_i = uns;
    bus.rsp_ready_i = rr;
    exp_ready = rst_n && (!exp_valid || rr);
    in_reset = !rst_n;
    #1;
    check("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
    @(posedge clk);
    if (in_reset) begin
      exp_valid = 1'b0; exp_rdata = '0; exp_we = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
    end else if (v && exp_ready) begin
      model_access(we, addr, wdata, size, uns);
      exp_valid = 1'b1;
    end else if (exp_valid && rr) exp_valid = 1'b0;
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_valid));
    if (exp_valid || in_reset) begin
      check("rsp_rdata", bus.rsp_rdata_o, exp_rdata);
      check("rsp_we", 32'(bus.rsp_we_o), 32'(exp_we));
      check("rsp_misalign", 32'(bus.rsp_misalign_o), 32'(exp_mis));
      check("rsp_bus_err", 32'(bus.rsp_bus_err_o), 32'(exp_err));
    end
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 32'h10, 32'h1, 2, 0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) cyc(1, 1, 32'(4*i), $urandom, 2, 0, 1);
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 2, 0, 1);
    check("sw_rsp_we", 32'(bus.rsp_we_o), 32'd1);
    cyc(1, 0, 32'h10, 0, 2, 0, 1);
    check("lw_deadbeef", bus.rsp_rdata_o, 32'hDEADBEEF);
    cyc(1, 1, 32'h11, 32'h80, 0, 0, 1);
    cyc(1, 0, 32'h11, 0, 0, 0, 1);
    check("lb_sext", bus.rsp_rdata_o, 32'hFFFFFF80);
    cyc(1, 0, 32'h11, 0, 0, 1, 1);
    check("lbu_zext", bus.rsp_rdata_o, 32'h00000080);
    cyc(1, 0, 32'h10, 0, 2, 0, 1);
    check("lw_merged", bus.rsp_rdata_o, 32'hDEAD80EF);
    cyc(1, 0, 32'h13, 0, 1, 0, 1);
    check("lh_misalign", 32'(bus.rsp_misalign_o), 32'd1);
    cyc(1, 1, 32'h12, 32'h1, 2, 0, 1);
    check("sw_misalign_we", {31'd0, bus.rsp_misalign_o} + {31'd0, bus.rsp_we_o}, 32'd2);
    cyc(1, 0, 32'h10, 0, 2, 0, 1);
    check("lw_after_fault", bus.rsp_rdata_o, 32'hDEAD80EF);
    cyc(1, 0, 32'h400, 0, 2, 0, 1);
    check("lw_oob", 32'(bus.rsp_bus_err_o), 32'd1);
    cyc(1, 1, 32'h20, 32'h55, 3, 0, 1);
    check("size3_err", 32'(bus.rsp_bus_err_o), 32'd1);
    cyc(1, 0, 32'h3FC, 0, 2, 0, 1);
    check("lw_top_ok", 32'(bus.rsp_bus_err_o), 32'd0);
    cyc(1, 0, 32'h10, 0, 2, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h3FC, 0, 2, 0, 0);
    cyc(1, 0, 32'h3FC, 0, 2, 0, 1);
    cyc(1, 0, 32'h10, 0, 1, 1, 1);
    check("lhu_low", bus.rsp_rdata_o, 32'h000080EF);
    rst_n = 1'b0;
    cyc(1, 1, 32'h20, 32'h12345678, 2, 0, 1);
    check("reset_drop", 32'(bus.rsp_valid_o), 32'd0);
    cyc(1, 1, 32'h20, 32'h12345678, 2, 0, 1);
    rst_n = 1'b1;
    cyc(1, 0, 32'h20, 0, 2, 0, 1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h43F)),
          $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
